// File: rtl/cola_prefetch_8088_pkg.sv
// Shared definitions for the 8088-style prefetch queue and operand capture.
// FSM encoding, queue-status codes and ModRM constants live here.
package cola_prefetch_8088_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MODRM  = 3'd1,
        ST_DISP_L = 3'd2,
        ST_DISP_H = 3'd3,
        ST_IMM    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] QS_IDLE   = 2'b00;
    localparam logic [1:0] QS_FIRST  = 2'b01;
    localparam logic [1:0] QS_FLUSH  = 2'b10;
    localparam logic [1:0] QS_SUBSEQ = 2'b11;

    localparam logic [1:0] MOD_MEM    = 2'b00;
    localparam logic [1:0] MOD_DISP16 = 2'b10;
    localparam logic [1:0] MOD_REG    = 2'b11;
    localparam logic [2:0] RM_DIRECT  = 3'b110;

    function automatic logic needs_disp16(input logic [1:0] m, input logic [2:0] rm);
        return (m == MOD_DISP16) || (m == MOD_MEM && rm == RM_DIRECT);
    endfunction

    // mod=01 and mod=10 always carry a displacement; mod=00 only for direct addressing.
    function automatic logic needs_disp(input logic [1:0] m, input logic [2:0] rm);
        return (m != MOD_REG) && (m != MOD_MEM || rm == RM_DIRECT);
    endfunction

    function automatic state_t after_fields(input logic imm);
        return imm ? ST_IMM : ST_DONE;
    endfunction

endpackage

// File: rtl/cola_prefetch_8088_fifo.sv
// Byte queue for the prefetch unit: power-of-two depth, wrapping pointers,
// flush clears everything and discards a same-cycle push.
module fifo_bytes_8088 #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;

    assign w_push  = i_push && !i_flush;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (i_pop)  r_rd <= r_rd + PW'(1);
            // push+pop together leaves the count alone
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cola_prefetch_8088.sv
// 8088-style prefetch queue with ModRM/displacement/immediate capture FSM.
// Optional QS queue-status output is enabled with QUEUE_STATUS_EN.
module cola_prefetch_8088
    import cola_prefetch_8088_pkg::*;
#(
    parameter int PROF = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              BusDato,
    input  logic                    BusValido,
    output logic                    BusListo,
    input  logic                    Flush,
    output logic                    OpValido,
    output logic [7:0]              OpDato,
    input  logic                    OpLeer,
    input  logic                    Start,
    input  logic                    ImmEn,
    output logic [1:0]              mod,
    output logic [2:0]              RM,
    output logic [23:0]             DESP,
    output logic                    Listo,
`ifdef QUEUE_STATUS_EN
    output logic [1:0]              QS,
`endif
    output state_t                  o_state,
    output logic [$clog2(PROF):0]   o_count
);
    localparam int            CW   = $clog2(PROF) + 1;
    localparam logic [CW-1:0] FULL = CW'(PROF);

    state_t        r_state;
    logic [1:0]    r_mod;
    logic [2:0]    r_rm;
    logic [23:0]   r_desp;
    logic          r_listo;
    logic          r_imm;

    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic          w_have;
    logic          w_push;
    logic          w_byte_st;
    logic          w_consume;
    logic          w_op_pop;
    logic          w_pop;

    assign w_have    = (w_count != '0);
    assign BusListo  = (w_count != FULL);
    assign w_push    = BusValido && BusListo;
    assign OpValido  = w_have && (r_state == ST_IDLE);
    assign w_op_pop  = OpLeer && OpValido;
    assign w_byte_st = (r_state == ST_MODRM) || (r_state == ST_DISP_L) ||
                       (r_state == ST_DISP_H) || (r_state == ST_IMM);
    assign w_consume = w_byte_st && w_have && !Flush;
    assign w_pop     = w_op_pop || w_consume;

    fifo_bytes_8088 #(.DEPTH(PROF)) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (Flush),
        .i_data  (BusDato),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign OpDato  = w_head;
    assign mod     = r_mod;
    assign RM      = r_rm;
    assign DESP    = r_desp;
    assign Listo   = r_listo;
    assign o_state = r_state;
    assign o_count = w_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_mod   <= '0;
            r_rm    <= '0;
            r_desp  <= '0;
            r_listo <= 1'b0;
            r_imm   <= 1'b0;
        end else begin
            r_listo <= 1'b0;
            if (Flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (Start) begin
                            r_desp  <= '0;
                            r_imm   <= ImmEn;
                            r_state <= ST_MODRM;
                        end
                    end
                    ST_MODRM: begin
                        if (w_have) begin
                            r_mod   <= w_head[7:6];
                            r_rm    <= w_head[2:0];
                            r_state <= needs_disp(w_head[7:6], w_head[2:0]) ?
                                       ST_DISP_L : after_fields(r_imm);
                        end
                    end
                    ST_DISP_L: begin
                        if (w_have) begin
                            r_desp[7:0] <= w_head;
                            r_state     <= needs_disp16(r_mod, r_rm) ?
                                           ST_DISP_H : after_fields(r_imm);
                        end
                    end
                    ST_DISP_H: begin
                        if (w_have) begin
                            r_desp[15:8] <= w_head;
                            r_state      <= after_fields(r_imm);
                        end
                    end
                    ST_IMM: begin
                        if (w_have) begin
                            r_desp[23:16] <= w_head;
                            r_state       <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_listo <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef QUEUE_STATUS_EN
    logic [1:0] r_qs;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_qs <= QS_IDLE;
        end else if (Flush) begin
            r_qs <= QS_FLUSH;
        end else if (w_consume) begin
            r_qs <= QS_SUBSEQ;
        end else if (w_op_pop) begin
            r_qs <= QS_FIRST;
        end else begin
            r_qs <= QS_IDLE;
        end
    end

    assign QS = r_qs;
`endif

endmodule
